seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Runtime-programmable serial pattern detector, a generalised successor to the fixed "110" detector. It watches a 1-bit stream qualified by a valid strobe and matches a pattern of 1 to MAX_LEN bits loaded at run time, in overlapping or non-overlapping mode. It provides both a Mealy (same-cycle) and a Moore (registered) match flag, plus an optional match counter. It sits between a serial input front-end and status/interrupt logic.

## Interface
- MAX_LEN, default 8: longest supported pattern in bits, minimum 2.
- CNT_W, default 8: match counter width.
- LEN_W, derived as $clog2(MAX_LEN+1): width of length fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- cfg_load  in  1  latch pat/pat_len/overlap; clears history.
- pat  in  MAX_LEN  pattern; bit pat_len-1 is expected first, bit 0 last.
- pat_len  in  LEN_W  pattern length.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  qualifies in.
- in  in  1  serial data bit.
- out_me  out  1  Mealy match, combinational.
- out_mo  out  1  Moore match, registered.
- fill  out  LEN_W  current matched-history depth (state).
- match_cnt  out  CNT_W  saturating match count; present only with SEQ_DET_CNT_EN.

## Operation
- Registered config: pat_r, len_r, ovl_r. Reset values: pat_r = 0, len_r = 0, ovl_r = 1.
- Length rules: len_r = 0 disables detection, so out_me = 0. pat_len > MAX_LEN is clamped to MAX_LEN at load.
- History: shift register hist[MAX_LEN-1:0], where hist[0] is the newest accepted bit. fill counts accepted bits and saturates at MAX_LEN.
- Mealy match, out_me = 1 when all of the following hold:
  - in_valid = 1;
  - len_r ≥ 1;
  - fill ≥ len_r-1;
  - {hist[len_r-2:0], in} == pat_r[len_r-1:0] (for len_r = 1, in == pat_r[0]).
- Accepted bit (in_valid = 1, cfg_load = 0): hist <= {hist[MAX_LEN-2:0], in}; fill <= min(fill+1, MAX_LEN).
- Non-overlap (ovl_r = 0): on a Mealy match, fill <= 0, so bits of the matched pattern cannot start a new match. History contents are don't-care once fill = 0.
- Overlap (ovl_r = 1): fill continues normally after a match.
- Moore output: out_mo <= out_me each cycle. It goes high exactly one cycle after the matching bit and stays high for one cycle per match.
- cfg_load wins over in_valid in the same cycle: the sample is discarded, fill <= 0, hist <= 0, out_mo <= 0.
- in_valid = 0: no state change; out_me = 0; out_mo <= 0.

## Timing
- Reset (rst = 0 at an edge): hist = 0, fill = 0, out_mo = 0, match_cnt = 0, config registers at their reset values. Reset mid-stream discards any partial match.
- out_me latency is 0 cycles (combinational from in, in_valid, state). out_mo latency is 1 cycle.
- Back-to-back valid bits are accepted every cycle. A new config takes effect on the first bit after the cfg_load edge.
- Consecutive matches, for example pattern "11" in overlap mode on "111", produce out_mo high on consecutive cycles.

## Configuration
- SEQ_DET_CNT_EN defined:
  - match_cnt port exists;
  - it increments on each Mealy match and saturates at 2^CNT_W-1;
  - it clears on reset and on cfg_load.
- SEQ_DET_CNT_EN undefined: the match_cnt port and its counter logic are absent. All other behaviour is identical.

## Structure
- Package seq_det_pkg holds:
  - the LEN_W helper function (clog2 of MAX_LEN+1);
  - mode constants SEQ_OVL = 1'b1 and SEQ_NOVL = 1'b0.
- Sub-module seq_match_cmp: combinational length-masked compare of {hist, in} against pat_r for a given len_r, returning the raw match. The top level owns the history, fill, Moore register and counter.

## Test plan
- Load pat = 3'b110, len 3, overlap=1; stream 1,1,0 → out_me = 1 on the cycle carrying the 0; out_mo = 1 one cycle later; fill reaches 3.
- Pattern "11", len 2, stream 1,1,1,1 → overlap=1: 3 matches (match_cnt = 3); overlap=0: 2 matches (match_cnt = 2).
- Pattern "110", stream 1,1, then in_valid = 0 for 3 cycles, then 0 → match on the final bit; no outputs during the gap.
- Stream 1,1; assert rst = 0 for one cycle; then 0 → no match; fill = 1 after the 0; out_mo = 0.
- cfg_load to pattern "01" len 2 in the same cycle as in_valid = 1, in = 1 → sample discarded; then 0,1 → out_me = 1 on the 1.
- CNT_W = 2 with SEQ_DET_CNT_EN defined; pattern "1" len 1; six 1s → match_cnt saturates at 3. pat_len = 15 with MAX_LEN = 8 → len clamps to 8.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared helpers and mode constants for seq_detector_param
package seq_det_pkg;

   localparam logic SEQ_OVL  = 1'b1;
   localparam logic SEQ_NOVL = 1'b0;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// rtl/seq_match_cmp.sv - length-masked compare of {hist, in} against the loaded pattern
module seq_match_cmp
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = len_w(MAX_LEN)
) (
   input  logic [MAX_LEN-2:0] hist,
   input  logic               in_bit,
   input  logic [MAX_LEN-1:0] pat,
   input  logic [LEN_W-1:0]   len,
   output logic               match
);

   logic [MAX_LEN-1:0] window;

   // window[0] is the incoming bit; only the low len positions take part
   always_comb begin
      window = {hist, in_bit};
      match  = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < len) && (window[i] != pat[i])) begin
            match = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial pattern detector (Mealy + Moore)
// Optional saturating match counter enabled by SEQ_DET_CNT_EN.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] pat,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic               overlap,
   input  logic               in_valid,
   input  logic               in,
   output logic               out_me,
   output logic               out_mo,
   output logic [LEN_W-1:0]   fill
`ifdef SEQ_DET_CNT_EN
   ,
   output logic [CNT_W-1:0]   match_cnt
`endif
);

   // The oldest history bit can never reach the compare window, so it is not stored.
   localparam int HW = MAX_LEN - 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   if ((MAX_LEN < 2) || (CNT_W < 1)) begin : g_bad_param
      $error("seq_detector_param: MAX_LEN must be >= 2 and CNT_W >= 1");
   end

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [HW-1:0]      hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               mo_q, mo_d;
   logic               raw_match;
   logic               fill_ok;

   seq_match_cmp #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_cmp (
      .hist   (hist_q),
      .in_bit (in),
      .pat    (pat_q),
      .len    (len_q),
      .match  (raw_match)
   );

   assign fill_ok = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
   assign out_me  = in_valid && (len_q != '0) && fill_ok && raw_match;
   assign out_mo  = mo_q;
   assign fill    = fill_q;

   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      mo_d   = out_me;
      if (cfg_load) begin
         pat_d  = pat;
         len_d  = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;
         ovl_d  = overlap;
         hist_d = '0;
         fill_d = '0;
         mo_d   = 1'b0;
      end else if (in_valid) begin
         hist_d = HW'({hist_q, in});
         if (out_me && (ovl_q == SEQ_NOVL)) begin
            fill_d = '0;
         end else if (fill_q != LEN_MAX) begin
            fill_d = fill_q + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pat_q  <= '0;
         len_q  <= '0;
         ovl_q  <= SEQ_OVL;
         hist_q <= '0;
         fill_q <= '0;
         mo_q   <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         mo_q   <= mo_d;
      end
   end

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cfg_load) begin
         cnt_d = '0;
      end else if (out_me && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed vector table plus randomized model check for seq_detector_param
module tb_seq_detector_param;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 2;
   localparam int LEN_W   = 4;
   localparam int CNT_MAX = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_load;
   logic [7:0]       pat;
   logic [3:0]       pat_len;
   logic             overlap;
   logic             in_valid;
   logic             in_b;
   logic             out_me;
   logic             out_mo;
   logic [3:0]       fill;
   logic [1:0]       match_cnt;

   always #5 clk = ~clk;

   seq_detector_param #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_load (cfg_load),
      .pat      (pat),
      .pat_len  (pat_len),
      .overlap  (overlap),
      .in_valid (in_valid),
      .in       (in_b),
      .out_me   (out_me),
      .out_mo   (out_mo),
      .fill     (fill)
`ifdef SEQ_DET_CNT_EN
      ,
      .match_cnt(match_cnt)
`endif
   );

`ifndef SEQ_DET_CNT_EN
   assign match_cnt = '0;
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference model: list of accepted bits since the last clear, newest at the back.
   bit         hq[$];
   logic [7:0] mp;
   int         ml;
   bit         movl;
   bit         mmo;
   int         mcnt;

   function automatic bit model_me(input bit v, input bit b);
      bit got;
      if (!v || ml == 0) return 1'b0;
      if (hq.size() < ml - 1) return 1'b0;
      for (int k = 0; k < ml; k++) begin
         got = (k == 0) ? b : hq[hq.size() - k];
         if (got != mp[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step(input bit ra, input bit cl, input logic [7:0] p, input logic [3:0] pl,
                             input bit ov, input bit v, input bit b);
      bit me;
      me = model_me(v, b);
      if (ra) begin
         hq.delete(); mp = '0; ml = 0; movl = 1'b1; mmo = 1'b0; mcnt = 0;
      end else if (cl) begin
         mp = p; ml = (int'(pl) > MAX_LEN) ? MAX_LEN : int'(pl); movl = ov;
         hq.delete(); mmo = 1'b0; mcnt = 0;
      end else begin
         mmo = me;
         if (v) begin
            if (me && mcnt < CNT_MAX) mcnt++;
            if (me && !movl) hq.delete();
            else begin
               hq.push_back(b);
               if (hq.size() > MAX_LEN) void'(hq.pop_front());
            end
         end
      end
   endtask

   bit s_me, s_mo, e_me;
   int s_fill, s_cnt;

   task automatic cyc(input bit ra, input bit cl, input logic [7:0] p, input logic [3:0] pl,
                      input bit ov, input bit v, input bit b);
      @(negedge clk);
      rst = !ra; cfg_load = cl; pat = p; pat_len = pl; overlap = ov; in_valid = v; in_b = b;
      #1;
      s_me = out_me;
      e_me = model_me(v, b);
      model_step(ra, cl, p, pl, ov, v, b);
      @(posedge clk);
      #1;
      s_mo = out_mo; s_fill = int'(fill); s_cnt = int'(match_cnt);
   endtask

   typedef struct {
      bit         ra;
      bit         cl;
      logic [7:0] p;
      logic [3:0] pl;
      bit         ov;
      bit         v;
      bit         b;
      bit         chk_me;
      bit         e_me;
      bit         e_mo;
      int         e_fill;
      int         e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic loadrow(input logic [7:0] p, input logic [3:0] pl, input bit ov);
      tbl.push_back('{1'b0, 1'b1, p, pl, ov, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
   endtask

   task automatic bitrow(input bit v, input bit b, input bit me, input bit mo, input int f, input int c);
      tbl.push_back('{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, v, b, 1'b1, me, mo, f, c});
   endtask

   initial begin
      logic [7:0] a5;
      bit         cl, ra, v, b, ov;
      logic [7:0] p;
      logic [3:0] pl;

      rst = 1'b0; cfg_load = 1'b0; pat = '0; pat_len = '0; overlap = 1'b1; in_valid = 1'b0; in_b = 1'b0;
      hq.delete(); mp = '0; ml = 0; movl = 1'b1; mmo = 1'b0; mcnt = 0;

      // Reset state; in_valid high with len 0 must not match.
      cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1);
      chk("rst_fill", s_fill, 0);
      chk("rst_mo", int'(s_mo), 0);
`ifdef SEQ_DET_CNT_EN
      chk("rst_cnt", s_cnt, 0);
`endif
      cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1);
      chk("len0_me", int'(s_me), 0);

      // "110" basic
      loadrow(8'h06, 4'd3, 1'b1);
      bitrow(1, 1, 0, 0, 1, 0);
      bitrow(1, 1, 0, 0, 2, 0);
      bitrow(1, 0, 1, 1, 3, 1);
      bitrow(0, 0, 0, 0, 3, 1);
      // "110" with an idle gap
      loadrow(8'h06, 4'd3, 1'b1);
      bitrow(1, 1, 0, 0, 1, 0);
      bitrow(1, 1, 0, 0, 2, 0);
      for (int i = 0; i < 3; i++) bitrow(0, 1, 0, 0, 2, 0);
      bitrow(1, 0, 1, 1, 3, 1);
      bitrow(0, 0, 0, 0, 3, 1);
      // reset mid-stream
      loadrow(8'h06, 4'd3, 1'b1);
      bitrow(1, 1, 0, 0, 1, 0);
      bitrow(1, 1, 0, 0, 2, 0);
      tbl.push_back('{1'b1, 1'b0, 8'h06, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0});
      bitrow(1, 0, 0, 0, 1, 0);
      // cfg_load collides with a valid sample
      tbl.push_back('{1'b0, 1'b1, 8'h01, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
      bitrow(1, 0, 0, 0, 1, 0);
      bitrow(1, 1, 1, 1, 2, 1);
      bitrow(0, 0, 0, 0, 2, 1);
      // "11" overlapping
      loadrow(8'h03, 4'd2, 1'b1);
      bitrow(1, 1, 0, 0, 1, 0);
      bitrow(1, 1, 1, 1, 2, 1);
      bitrow(1, 1, 1, 1, 3, 2);
      bitrow(1, 1, 1, 1, 4, 3);
      bitrow(0, 0, 0, 0, 4, 3);
      // "11" non-overlapping
      loadrow(8'h03, 4'd2, 1'b0);
      bitrow(1, 1, 0, 0, 1, 0);
      bitrow(1, 1, 1, 1, 0, 1);
      bitrow(1, 1, 0, 0, 1, 1);
      bitrow(1, 1, 1, 1, 0, 2);
      bitrow(0, 0, 0, 0, 0, 2);
      // "1" length 1, counter saturation
      loadrow(8'h01, 4'd1, 1'b1);
      for (int i = 1; i <= 6; i++) bitrow(1, 1, 1, 1, i, (i > CNT_MAX) ? CNT_MAX : i);
      // length 15 clamps to 8
      loadrow(8'hA5, 4'd15, 1'b1);
      a5 = 8'hA5;
      for (int k = 7; k >= 0; k--) bitrow(1, a5[k], k == 0, k == 0, 8 - k, (k == 0) ? 1 : 0);
      bitrow(1, 0, 0, 0, 8, 1);

      foreach (tbl[i]) begin
         cyc(tbl[i].ra, tbl[i].cl, tbl[i].p, tbl[i].pl, tbl[i].ov, tbl[i].v, tbl[i].b);
         if (tbl[i].chk_me) chk($sformatf("v%0d_me", i), int'(s_me), int'(tbl[i].e_me));
         chk($sformatf("v%0d_mo", i), int'(s_mo), int'(tbl[i].e_mo));
         chk($sformatf("v%0d_fill", i), s_fill, tbl[i].e_fill);
`ifdef SEQ_DET_CNT_EN
         chk($sformatf("v%0d_cnt", i), s_cnt, tbl[i].e_cnt);
`endif
      end

      // Randomized stream against the model.
      p = 8'h00; pl = 4'd0; ov = 1'b1;
      for (int n = 0; n < 600; n++) begin
         ra = ($urandom_range(0, 199) == 0);
         cl = (n == 0) || ($urandom_range(0, 29) == 0);
         if (cl) begin
            p  = 8'($urandom());
            pl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 3));
            ov = 1'($urandom_range(0, 1));
         end
         v = ($urandom_range(0, 3) != 0);
         b = 1'($urandom_range(0, 1));
         cyc(ra, cl, p, pl, ov, v, b);
         if (!cl) chk($sformatf("r%0d_me", n), int'(s_me), int'(e_me));
         chk($sformatf("r%0d_mo", n), int'(s_mo), int'(mmo));
         chk($sformatf("r%0d_fill", n), s_fill, hq.size());
`ifdef SEQ_DET_CNT_EN
         chk($sformatf("r%0d_cnt", n), s_cnt, mcnt);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
